// File: rtl/vector_proc_arbiter_if.sv
// Handshake bundle shared by the shader requesters, the arbiter and the vector processor.
// The arbiter uses the slave modport; the surrounding environment drives the master side.
interface vector_proc_arbiter_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int VECTOR_WIDTH = 4,
   parameter int NUM_REQ      = 4,
   parameter int REQ_ID_WIDTH = 2
);
   localparam int VEC_W = VECTOR_WIDTH * DATA_WIDTH;

   logic [NUM_REQ-1:0]            req_start;
   logic [NUM_REQ*4-1:0]          req_operation;
   logic [NUM_REQ*VEC_W-1:0]      req_vec_a;
   logic [NUM_REQ*VEC_W-1:0]      req_vec_b;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_scalar;
   logic [NUM_REQ-1:0]            req_busy;
   logic [NUM_REQ-1:0]            req_done;
   logic [VEC_W-1:0]              req_result;
   logic [NUM_REQ-1:0]            req_result_valid;

   logic                          vp_start;
   logic [3:0]                    vp_operation;
   logic [VEC_W-1:0]              vp_vec_a;
   logic [VEC_W-1:0]              vp_vec_b;
   logic [DATA_WIDTH-1:0]         vp_scalar;
   logic                          vp_busy;
   logic                          vp_done;
   logic [VEC_W-1:0]              vp_result;
   logic                          vp_result_valid;

   logic [REQ_ID_WIDTH-1:0]       grant_id;
   logic                          timeout_err;
   logic                          drop_err;

   modport slave (
      input  req_start, req_operation, req_vec_a, req_vec_b, req_scalar,
      output req_busy, req_done, req_result, req_result_valid,
      output vp_start, vp_operation, vp_vec_a, vp_vec_b, vp_scalar,
      input  vp_busy, vp_done, vp_result, vp_result_valid,
      output grant_id, timeout_err, drop_err
   );

   modport master (
      output req_start, req_operation, req_vec_a, req_vec_b, req_scalar,
      input  req_busy, req_done, req_result, req_result_valid,
      input  vp_start, vp_operation, vp_vec_a, vp_vec_b, vp_scalar,
      output vp_busy, vp_done, vp_result, vp_result_valid,
      input  grant_id, timeout_err, drop_err
   );
endinterface

// File: rtl/vector_proc_arbiter.sv
// Round-robin arbiter sharing one vector processor between NUM_REQ shader pipelines,
// with a holding slot per requester and one operation in flight at a time.
module vector_proc_arbiter #(
   parameter int DATA_WIDTH     = 16,
   parameter int VECTOR_WIDTH   = 4,
   parameter int NUM_REQ        = 4,
   parameter int REQ_ID_WIDTH   = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                 clk,
   input logic                 rst_n,
   vector_proc_arbiter_if.slave bus
);
   localparam int VEC_W  = VECTOR_WIDTH * DATA_WIDTH;
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                  state;
   logic [NUM_REQ-1:0]      slot_valid;
   logic [3:0]              slot_op     [NUM_REQ];
   logic [VEC_W-1:0]        slot_a      [NUM_REQ];
   logic [VEC_W-1:0]        slot_b      [NUM_REQ];
   logic [DATA_WIDTH-1:0]   slot_scalar [NUM_REQ];
   logic [REQ_ID_WIDTH-1:0] rr_ptr;
   logic [WAIT_W-1:0]       wait_cnt;

   logic [NUM_REQ-1:0]      pending;
   logic                    pick_found;
   logic [REQ_ID_WIDTH-1:0] pick_id;
   logic [REQ_ID_WIDTH-1:0] cand;
   logic [REQ_ID_WIDTH-1:0] next_ptr;
   logic                    vp_done_unused;

   // A slot stays valid through its result strobe cycle so req_busy covers it; it must not be re-issued then.
   assign pending        = slot_valid & ~bus.req_result_valid;
   assign bus.req_busy   = slot_valid;
   assign next_ptr       = REQ_ID_WIDTH'((int'(bus.grant_id) + 1) % NUM_REQ);
   assign vp_done_unused = bus.vp_done;

   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = REQ_ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
         if (pending[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                <= IDLE;
         slot_valid           <= '0;
         rr_ptr               <= '0;
         wait_cnt             <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_op[i]     <= '0;
            slot_a[i]      <= '0;
            slot_b[i]      <= '0;
            slot_scalar[i] <= '0;
         end
         bus.req_done         <= '0;
         bus.req_result       <= '0;
         bus.req_result_valid <= '0;
         bus.vp_start         <= 1'b0;
         bus.vp_operation     <= '0;
         bus.vp_vec_a         <= '0;
         bus.vp_vec_b         <= '0;
         bus.vp_scalar        <= '0;
         bus.grant_id         <= '0;
         bus.timeout_err      <= 1'b0;
         bus.drop_err         <= 1'b0;
      end else begin
         bus.vp_start         <= 1'b0;
         bus.req_done         <= '0;
         bus.req_result_valid <= '0;

         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_result_valid[i]) begin
               slot_valid[i] <= 1'b0;
            end else if (bus.req_start[i] && !slot_valid[i]) begin
               slot_valid[i]  <= 1'b1;
               slot_op[i]     <= bus.req_operation[4*i +: 4];
               slot_a[i]      <= bus.req_vec_a[VEC_W*i +: VEC_W];
               slot_b[i]      <= bus.req_vec_b[VEC_W*i +: VEC_W];
               slot_scalar[i] <= bus.req_scalar[DATA_WIDTH*i +: DATA_WIDTH];
            end
         end

         if (|(bus.req_start & slot_valid)) begin
            bus.drop_err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (pick_found && !bus.vp_busy) begin
                  bus.vp_start     <= 1'b1;
                  bus.vp_operation <= slot_op[pick_id];
                  bus.vp_vec_a     <= slot_a[pick_id];
                  bus.vp_vec_b     <= slot_b[pick_id];
                  bus.vp_scalar    <= slot_scalar[pick_id];
                  bus.grant_id     <= pick_id;
                  wait_cnt         <= '0;
                  state            <= WAIT;
               end
            end
            WAIT: begin
               if (bus.vp_result_valid) begin
                  bus.req_result                 <= bus.vp_result;
                  bus.req_result_valid[bus.grant_id] <= 1'b1;
                  bus.req_done[bus.grant_id]     <= 1'b1;
                  rr_ptr                         <= next_ptr;
                  state                          <= IDLE;
               end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  bus.req_result                 <= '0;
                  bus.req_result_valid[bus.grant_id] <= 1'b1;
                  bus.req_done[bus.grant_id]     <= 1'b1;
                  bus.timeout_err                <= 1'b1;
                  rr_ptr                         <= next_ptr;
                  state                          <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_proc_arbiter.sv
// Self-checking bench: a slot/queue reference model compared every cycle, a small vector
// processor emulator (op 4'hF never answers), and directed scenarios with literal expectations.
module tb_vector_proc_arbiter;
   localparam int DW  = 16;
   localparam int VW  = 4;
   localparam int NR  = 4;
   localparam int IDW = 2;
   localparam int TO  = 255;
   localparam int VEC = VW * DW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   check_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vector_proc_arbiter_if #(.DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .NUM_REQ(NR), .REQ_ID_WIDTH(IDW)) bus ();

   vector_proc_arbiter #(
      .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .NUM_REQ(NR), .REQ_ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model state: which requesters hold work, who owns the processor, whose turn is next.
   bit              m_valid [NR];
   logic [3:0]      m_op    [NR];
   logic [VEC-1:0]  m_a     [NR];
   logic [VEC-1:0]  m_b     [NR];
   logic [DW-1:0]   m_s     [NR];
   int              m_owner = -1;
   int              m_rr    = 0;
   int              m_waited = 0;

   logic            e_vp_start;
   logic [3:0]      e_vp_op;
   logic [VEC-1:0]  e_vp_a, e_vp_b, e_result;
   logic [DW-1:0]   e_vp_s;
   logic [IDW-1:0]  e_grant;
   logic [NR-1:0]   e_rv, e_done;
   logic            e_terr, e_drop;

   longint vs_t[$];
   int     vs_id[$];
   longint rv_t[$];
   int     rv_bits[$];
   logic [VEC-1:0] rv_res[$];

   int             emu_cnt = -1;
   logic [VEC-1:0] emu_res;

   task automatic deliver(input logic [VEC-1:0] value);
      e_result        = value;
      e_rv[m_owner]   = 1'b1;
      e_done[m_owner] = 1'b1;
      m_rr            = (m_owner + 1) % NR;
      m_owner         = -1;
   endtask

   always @(posedge clk) begin : model
      bit            snap_valid [NR];
      logic [NR-1:0] snap_rv;
      int            j;
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
         m_owner = -1; m_rr = 0; m_waited = 0;
         e_vp_start = 0; e_vp_op = '0; e_vp_a = '0; e_vp_b = '0; e_vp_s = '0;
         e_grant = '0; e_rv = '0; e_done = '0; e_result = '0; e_terr = 0; e_drop = 0;
      end else begin
         snap_valid = m_valid;
         snap_rv    = e_rv;
         e_vp_start = 1'b0;
         e_rv       = '0;
         e_done     = '0;
         for (int i = 0; i < NR; i++) begin
            if (bus.req_start[i] && snap_valid[i]) e_drop = 1'b1;
            if (snap_rv[i]) m_valid[i] = 1'b0;
            else if (bus.req_start[i] && !snap_valid[i]) begin
               m_valid[i] = 1'b1;
               m_op[i]    = bus.req_operation[4*i +: 4];
               m_a[i]     = bus.req_vec_a[VEC*i +: VEC];
               m_b[i]     = bus.req_vec_b[VEC*i +: VEC];
               m_s[i]     = bus.req_scalar[DW*i +: DW];
            end
         end
         if (m_owner < 0) begin
            if (!bus.vp_busy) begin
               for (int k = 0; k < NR; k++) begin
                  j = (m_rr + k) % NR;
                  if (m_owner < 0 && snap_valid[j] && !snap_rv[j]) begin
                     m_owner = j; m_waited = 0; e_vp_start = 1'b1; e_grant = IDW'(j);
                     e_vp_op = m_op[j]; e_vp_a = m_a[j]; e_vp_b = m_b[j]; e_vp_s = m_s[j];
                  end
               end
            end
         end else begin
            m_waited++;
            if (bus.vp_result_valid) deliver(bus.vp_result);
            else if (m_waited == TO) begin
               deliver('0);
               e_terr = 1'b1;
            end
         end
      end
   end

   // Processor stand-in: answers three cycles after vp_start with (a+b) xor the replicated scalar.
   always @(negedge clk) begin : emulator
      bus.vp_result_valid = 1'b0;
      bus.vp_done         = 1'b0;
      if (emu_cnt > 0) begin
         emu_cnt--;
         if (emu_cnt == 0) begin
            bus.vp_result_valid = 1'b1;
            bus.vp_done         = 1'b1;
            emu_cnt             = -1;
         end
      end
      if (bus.vp_start === 1'b1 && bus.vp_operation !== 4'hF) begin
         emu_cnt = 3;
         emu_res = (bus.vp_vec_a + bus.vp_vec_b) ^ {VW{bus.vp_scalar}};
      end
      bus.vp_busy   = (emu_cnt > 0);
      bus.vp_result = bus.vp_result_valid ? emu_res : '0;
   end

   task automatic check_output(input string name, input logic [VEC-1:0] act, input logic [VEC-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : compare
      if (check_en) begin
         check_output("vp_start",         VEC'(bus.vp_start),         VEC'(e_vp_start));
         check_output("vp_operation",     VEC'(bus.vp_operation),     VEC'(e_vp_op));
         check_output("vp_vec_a",         bus.vp_vec_a,               e_vp_a);
         check_output("vp_vec_b",         bus.vp_vec_b,               e_vp_b);
         check_output("vp_scalar",        VEC'(bus.vp_scalar),        VEC'(e_vp_s));
         check_output("grant_id",         VEC'(bus.grant_id),         VEC'(e_grant));
         check_output("req_busy",         VEC'(bus.req_busy),         VEC'({m_valid[3], m_valid[2], m_valid[1], m_valid[0]}));
         check_output("req_done",         VEC'(bus.req_done),         VEC'(e_done));
         check_output("req_result_valid", VEC'(bus.req_result_valid), VEC'(e_rv));
         check_output("req_result",       bus.req_result,             e_result);
         check_output("timeout_err",      VEC'(bus.timeout_err),      VEC'(e_terr));
         check_output("drop_err",         VEC'(bus.drop_err),         VEC'(e_drop));
         if (bus.vp_start === 1'b1) begin
            vs_t.push_back(longint'($time));
            vs_id.push_back(int'(bus.grant_id));
         end
         if (bus.req_result_valid !== '0) begin
            rv_t.push_back(longint'($time));
            rv_bits.push_back(int'(bus.req_result_valid));
            rv_res.push_back(bus.req_result);
         end
      end
   end

   function automatic int pack(input int q[$], input int offset);
      int v;
      v = 0;
      foreach (q[i]) v = v * 16 + q[i] + offset;
      return v;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.req_start = '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic clear_logs();
      vs_t.delete(); vs_id.delete(); rv_t.delete(); rv_bits.delete(); rv_res.delete();
   endtask

   task automatic apply_stimulus(input int r, input logic [3:0] op, input logic [VEC-1:0] a,
                                 input logic [VEC-1:0] b, input logic [DW-1:0] s);
      bus.req_operation[4*r +: 4] = op;
      bus.req_vec_a[VEC*r +: VEC] = a;
      bus.req_vec_b[VEC*r +: VEC] = b;
      bus.req_scalar[DW*r +: DW]  = s;
      bus.req_start[r]            = 1'b1;
   endtask

   task automatic apply_default(input int r, input logic [3:0] op);
      apply_stimulus(r, op, 64'h0001_0001_0001_0001 * 64'(r + 1),
                     64'h0101_0202_0303_0404 + 64'(r), DW'(16'h0100 + r));
   endtask

   initial begin
      bus.req_start = '0; bus.req_operation = '0; bus.req_vec_a = '0;
      bus.req_vec_b = '0; bus.req_scalar = '0;
      @(negedge clk);
      check_en = 1'b1;
      do_reset();
      check_output("reset_busy",  VEC'(bus.req_busy), '0);
      check_output("reset_flags", VEC'({bus.timeout_err, bus.drop_err}), '0);

      // Single request from requester 2.
      clear_logs();
      begin
         longint t0;
         t0 = longint'($time);
         apply_stimulus(2, 4'h4, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 16'h0080);
         step(10);
         check_output("t1_grants",       VEC'(pack(vs_id, 1)), VEC'(32'h3));
         check_output("t1_start_delay",  VEC'(vs_t[0] - t0), VEC'(20));
         check_output("t1_rv_owner",     VEC'(pack(rv_bits, 0)), VEC'(32'h4));
         check_output("t1_rv_delay",     VEC'(rv_t[0] - vs_t[0]), VEC'(40));
         check_output("t1_result",       rv_res[0], 64'h0091_00A2_00B3_00C4);
         check_output("t1_busy_cleared", VEC'(bus.req_busy), '0);
      end

      // All four requesters at once.
      do_reset(); clear_logs();
      for (int r = 0; r < NR; r++) apply_default(r, 4'(r + 1));
      step(40);
      check_output("t2_grant_order", VEC'(pack(vs_id, 1)), VEC'(32'h1234));
      check_output("t2_rv_owners",   VEC'(pack(rv_bits, 0)), VEC'(32'h1248));

      // Round-robin resumes after the last owner.
      do_reset(); clear_logs();
      apply_default(1, 4'h2);
      step(3);
      apply_default(0, 4'h3);
      apply_default(3, 4'h5);
      step(30);
      check_output("t3_grant_order", VEC'(pack(vs_id, 1)), VEC'(32'h241));

      // Second start while busy is dropped.
      do_reset(); clear_logs();
      apply_default(0, 4'h6);
      step(2);
      apply_default(0, 4'h7);
      step(15);
      check_output("t4_drop_err",  VEC'(bus.drop_err), VEC'(1));
      check_output("t4_one_grant", VEC'(pack(vs_id, 1)), VEC'(32'h1));
      check_output("t4_one_rv",    VEC'(pack(rv_bits, 0)), VEC'(32'h1));

      // Processor never answers requester 1; requester 3 follows after the timeout.
      do_reset(); clear_logs();
      apply_default(1, 4'hF);
      apply_default(3, 4'h2);
      step(275);
      check_output("t5_grant_order", VEC'(pack(vs_id, 1)), VEC'(32'h24));
      check_output("t5_rv_owners",   VEC'(pack(rv_bits, 0)), VEC'(32'h28));
      check_output("t5_timeout_lat", VEC'(rv_t[0] - vs_t[0]), VEC'(2550));
      check_output("t5_zero_result", rv_res[0], '0);
      check_output("t5_timeout_err", VEC'(bus.timeout_err), VEC'(1));

      // Reset while an operation is in flight; the late answer must be ignored.
      do_reset(); clear_logs();
      apply_default(2, 4'h1);
      step(3);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      clear_logs();
      step(10);
      check_output("t6_no_rv",    VEC'(rv_bits.size()), '0);
      check_output("t6_no_start", VEC'(vs_t.size()), '0);
      check_output("t6_busy",     VEC'(bus.req_busy), '0);
      check_output("t6_flags",    VEC'({bus.timeout_err, bus.drop_err}), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vector_proc_arbiter.md
Name: vector_proc_arbiter

Overview:
Shares one vector processor between NUM_REQ shader pipelines.
- Each requester issues a one-cycle start pulse with its operands; the arbiter captures them in a per-requester holding slot.
- Slots are granted round-robin, one operation in flight at a time.
- The result is routed back only to the owning requester.
- Sits between the shader pipelines and the vector processor; each requester sees the same start/busy/done/result handshake it would see from the processor directly.

Parameters:
DATA_WIDTH, 16, fixed-point word width (8.8)
VECTOR_WIDTH, 4, components per vector
NUM_REQ, 4, number of requesters (2..8)
REQ_ID_WIDTH, 2, width of grant index, equals clog2(NUM_REQ)
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before forced completion

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
req_start  in  NUM_REQ  per-requester one-cycle start pulse
req_operation  in  NUM_REQ*4  per-requester opcode, requester i at [4i+3:4i]
req_vec_a  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  per-requester operand A
req_vec_b  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  per-requester operand B
req_scalar  in  NUM_REQ*DATA_WIDTH  per-requester scalar
req_busy  out  NUM_REQ  slot i occupied (pending or in flight)
req_done  out  NUM_REQ  one-cycle completion pulse to owner
req_result  out  VECTOR_WIDTH*DATA_WIDTH  shared result bus, valid for owner when its req_result_valid is high
req_result_valid  out  NUM_REQ  one-cycle result strobe to owner
vp_start  out  1  start pulse to vector processor
vp_operation  out  4  opcode to processor
vp_vec_a  out  VECTOR_WIDTH*DATA_WIDTH  operand A to processor
vp_vec_b  out  VECTOR_WIDTH*DATA_WIDTH  operand B to processor
vp_scalar  out  DATA_WIDTH  scalar to processor
vp_busy  in  1  processor busy
vp_done  in  1  processor done (informational, not used for sequencing)
vp_result  in  VECTOR_WIDTH*DATA_WIDTH  processor result
vp_result_valid  in  1  processor result strobe
grant_id  out  REQ_ID_WIDTH  owner of current or last operation
timeout_err  out  1  sticky: a WAIT timed out
drop_err  out  1  sticky: a start was ignored because the slot was busy

Behaviour:
- Clocking and reset: single clock domain. Synchronous active-low reset clears the following:
  - all slots, rr_ptr=0, FSM=IDLE, wait counter;
  - all outputs to 0, including the sticky error flags.
  - Reset during WAIT abandons the operation; a later vp_result_valid while in IDLE is ignored.
- Slot capture: at an edge where req_start[i]=1 and slot i is empty, the operands are latched and slot i becomes valid.
  - req_busy[i] is high from the next cycle until the cycle req_result_valid[i] is high, inclusive.
  - If req_start[i]=1 while req_busy[i]=1, the start is ignored, the slot is unchanged, and drop_err is set.
  - A start in the same cycle as that requester's result strobe is also ignored.
- FSM states: IDLE, WAIT.
- IDLE:
  - If any slot is pending, not in flight, and vp_busy=0, pick the first pending index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register that slot's operands onto vp_*, pulse vp_start for exactly one cycle, set grant_id, clear the wait counter, go to WAIT.
  - If vp_busy=1, hold and do not issue.
  - Fixed latency: start pulse at edge E0 gives vp_start high after E1 (minimum 2 cycles).
- vp_* operand outputs hold their value until the next issue.
- WAIT:
  - The wait counter increments every cycle.
  - On vp_result_valid=1: register vp_result onto req_result, and pulse req_result_valid[grant_id] and req_done[grant_id] for one cycle (next cycle). Clear the slot, set rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES without vp_result_valid: deliver req_result=0 with the same strobes, set timeout_err, clear the slot, advance rr_ptr, go to IDLE.
  - New starts are still captured into other empty slots while in WAIT.
- vp_result_valid in IDLE is ignored.
- req_result holds its last value between strobes.
- Fairness: with all slots continuously pending, each requester is issued once per NUM_REQ operations.

Test Plan:
1. Single request: req_start[2] pulse, opcode 4, scalar 0x0080, vp returns result 3 cycles after vp_start -> vp_start 2 cycles after req_start, grant_id=2, req_result_valid=4'b0100 one cycle later with matching data, req_busy[2] cleared.
2. All four requesters pulse start in the same cycle after reset -> vp_start grants in order 0,1,2,3; each req_result_valid goes only to its owner.
3. After requester 1 finishes, requesters 0 and 3 are pending -> 3 is granted first (rr_ptr=2); then 0.
4. req_start[0] twice, 2 cycles apart, while the first is in flight -> second start ignored, drop_err=1, exactly one result to requester 0.
5. Processor never asserts vp_result_valid -> after 255 WAIT cycles req_result=0, req_result_valid pulsed to owner, timeout_err=1, next pending slot issued.
6. rst_n low for one edge during WAIT, processor returns result afterwards -> no req_result_valid, all req_busy=0, vp_start stays 0, error flags 0.
